// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle radix-2 multiply/divide unit producing the HI/LO pair.
//   MULT/MULTU give the exact 2W-bit product (hi:lo).
//   DIV/DIVU give quotient in lo and remainder in hi. The quotient truncates
//   toward zero and the remainder takes the sign of the dividend.
//   Latency is fixed at WIDTH+2 cycles from the accepting edge to done.
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        request, sampled only while idle
//   op_i           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i, b_i       multiplicand/dividend, multiplier/divisor
//   busy_o         operation in progress (PREP, RUN, FIX)
//   done_o         one-cycle pulse, hi_o/lo_o updated
//   hi_o, lo_o     product upper/lower half, or remainder/quotient
//   div_by_zero_o  qualifies done_o for a divide with b = 0
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_e;

  state_e         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;     // raw captured operands
  logic [W-1:0]   mc_q, mc_d;             // multiplicand magnitude, or divisor magnitude
  logic [W-1:0]   mp_q, mp_d;             // multiplier magnitude, consumed LSB first
  logic [2*W-1:0] acc_q, acc_d;           // product, or {rem, quo}
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           negp_q, negp_d;         // product / quotient sign
  logic           negr_q, negr_d;         // remainder sign
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           done_q, done_d, dbz_q, dbz_d;

  logic           is_div, sgn_op;
  logic [W-1:0]   abs_a, abs_b;
  logic [W:0]     sum, rem_sh, diff;
  logic [2*W:0]   mul_add;
  logic [2*W-1:0] mul_next, div_next, prod;
  logic [W-1:0]   quo, rem;

  assign is_div = op_q[1];
  assign sgn_op = ~op_q[0];
  assign abs_a  = (sgn_op && a_q[W-1]) ? -a_q : a_q;
  assign abs_b  = (sgn_op && b_q[W-1]) ? -b_q : b_q;

  // Shift-add step: the add can carry out of the upper half, so the carry
  // is kept as an extra top bit and falls back in on the right shift.
  assign sum      = {1'b0, acc_q[2*W-1:W]} + {1'b0, mc_q};
  assign mul_add  = mp_q[0] ? {sum, acc_q[W-1:0]} : {1'b0, acc_q};
  assign mul_next = mul_add[2*W:1];

  // Restoring divide step: rem shifted left is W+1 bits wide, bit W of the
  // difference is the borrow.
  assign rem_sh   = acc_q[2*W-1:W-1];
  assign diff     = rem_sh - {1'b0, mc_q};
  assign div_next = diff[W] ? {acc_q[2*W-2:0], 1'b0}
                            : {diff[W-1:0], acc_q[W-2:0], 1'b1};

  assign prod = negp_q ? -acc_q : acc_q;
  assign quo  = negp_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem  = negr_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        negp_d  = sgn_op & (a_q[W-1] ^ b_q[W-1]);
        negr_d  = sgn_op & a_q[W-1];
        mc_d    = is_div ? abs_b : abs_a;
        mp_d    = abs_b;
        // The dividend rides in the low half and is shifted out into rem.
        acc_d   = is_div ? {{W{1'b0}}, abs_a} : '0;
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        acc_d = is_div ? div_next : mul_next;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (!is_div) begin
          {hi_d, lo_d} = prod;
        end else if (b_q == '0) begin
          // Divide by zero runs the full latency, then reports a fixed result.
          dbz_d = 1'b1;
          hi_d  = a_q;
          lo_d  = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit (WIDTH=32): a cycle-level reference model built from
// plain 64-bit arithmetic and a latency countdown, checked every cycle, plus
// directed vectors with hand-computed results, latency and busy length.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int n_vec = 0, n_fail = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo), .div_by_zero_o(dbz)
  );

  // Result as {div_by_zero, hi, lo}.
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, y);
    longint     sx, sy;
    logic [63:0] ux, uy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: begin p = 64'(sx * sy); return {1'b0, p}; end
      2'b01: begin p = ux * uy;      return {1'b0, p}; end
      default: begin
        if (y == '0) return {1'b1, x, {W{1'b1}}};
        if (o == 2'b10) begin q = 64'(sx / sy); r = 64'(sx % sy); end
        else begin q = ux / uy; r = ux % uy; end
        return {1'b0, r[W-1:0], q[W-1:0]};
      end
    endcase
  endfunction

  // Reference: idle when m_cnt==0; an accepted op finishes W+2 edges later.
  int           m_cnt = 0;
  logic [2*W:0] pend = '0;
  logic         m_done = 1'b0, m_dbz = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= 0; m_done <= 1'b0; m_dbz <= 1'b0; m_hi <= '0; m_lo <= '0;
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_dbz  <= pend[2*W];
          m_hi   <= pend[2*W-1:W];
          m_lo   <= pend[W-1:0];
        end
      end else if (start) begin
        pend  <= model(op, a, b);
        m_cnt <= W + 2;
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!done && lat < 100) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] x, y,
                        input logic [W-1:0] eh, el, input logic ed);
    int lat, bc;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    chk({nm, " latency"}, W'(lat), 32'd34);
    chk({nm, " busy_len"}, W'(bc), 32'd34);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    chk({nm, " dbz"}, W'(dbz), W'(ed));
  endtask

  initial begin
    int lat, bc, nd;
    repeat (2) @(negedge clk);
    chk("reset busy", W'(busy), 32'd0);
    chk("reset done", W'(done), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        n_vec++;
        if ({busy, done, dbz, hi, lo} !== {(m_cnt != 0), m_done, m_dbz, m_hi, m_lo}) begin
          n_fail++;
          $display("FAIL cycle: busy=%b done=%b dbz=%b hi=%h lo=%h, model busy=%b done=%b dbz=%b hi=%h lo=%h",
                   busy, done, dbz, hi, lo, (m_cnt != 0), m_done, m_dbz, m_hi, m_lo);
        end
      end
    join_none

    run_op("mult_neg1x2", 2'b00, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("multu_max_x2", 2'b01, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_op("mult_neg3xneg5", 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'd15, 1'b0);
    run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu_by0", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1);
    run_op("multu_3x5", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    run_op("div_by0_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

    // Inputs churn and a start pulse lands mid-run; result must follow the
    // captured operands. Then a start in the done cycle is taken at once.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'h0001_0000; b = 32'h0001_0000;
    @(negedge clk);
    lat = 0;
    while (!done && lat < 100) begin
      start = (lat == 10);
      a = $urandom;
      b = $urandom;
      op = 2'($urandom_range(0, 3));
      @(negedge clk);
      lat++;
    end
    chk("ignore_start latency", W'(lat), 32'd34);
    chk("ignore_start hi", hi, 32'd1);
    chk("ignore_start lo", lo, 32'd0);
    start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    chk("b2b latency", W'(lat), 32'd34);
    chk("b2b lo", lo, 32'd42);

    // Reset at RUN iteration 15 discards the op.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFD; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst busy", W'(busy), 32'd0);
    chk("midrun_rst hi", hi, 32'd0);
    chk("midrun_rst lo", lo, 32'd0);
    nd = 0;
    repeat (40) begin @(negedge clk); if (done) nd++; end
    chk("midrun_rst no_done", W'(nd), 32'd0);
    run_op("after_rst mult", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

    // Reset and start on the same edge: the start is lost.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start busy", W'(busy), 32'd0);
    nd = 0;
    repeat (40) begin @(negedge clk); if (done) nd++; end
    chk("rst_start no_done", W'(nd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
